// File: rtl/bcd_pkg.sv
// Shared constants for the serial BCD adder.
// FSM encoding, segment patterns and BCD limits.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low, segment a is index 0, g is index 6.
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] SEG_TABLE [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    function automatic logic [0:6] seg_of(input logic [3:0] d);
        logic [0:6] r;
        r = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == i[3:0]) r = SEG_TABLE[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_bcd_to_7seg.sv
// Single BCD digit to active-low 7-segment decoder.
// Ports: digit (4-bit BCD in), seg ([0:6] = a..g, blank for >9).
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    assign seg = seg_of(digit);

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder, one digit per clock, start/busy/done handshake.
// Ports: clk, rst_n, start, a, b, cin -> busy, done, sum, cout, err, hex.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    err,
    output logic [7*(DIGITS+1)-1:0] hex
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                carry;

    logic                bad;
    logic [3:0]          da;
    logic [3:0]          db;
    logic [4:0]          t;
    logic                gt;
    logic [3:0]          dsum;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX)
                bad = 1'b1;
        end
    end

    always_comb begin
        da   = a_q[4*idx +: 4];
        db   = b_q[4*idx +: 4];
        t    = {1'b0, da} + {1'b0, db} + {4'b0, carry};
        gt   = (t > 5'd9);
        // Adding 6 modulo 16 is the same as subtracting 10 for t in 10..19.
        dsum = gt ? (t[3:0] + 4'd6) : t[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= bad;
                        state <= bad ? ST_DONE : ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum[4*idx +: 4] <= dsum;
                    carry           <= gt;
                    if (idx == LAST) begin
                        cout  <= gt;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Feeding 4'hF into the decoder blanks the field when err is set.
    for (genvar j = 0; j < DIGITS; j++) begin : g_dig
        logic [3:0] nib;
        logic [0:6] seg;
        assign nib = err ? 4'hF : sum[4*j +: 4];
        bcd_to_7seg u_seg (
            .digit (nib),
            .seg   (seg)
        );
        assign hex[7*j +: 7] = seg;
    end

    logic [3:0] cnib;
    logic [0:6] cseg;
    assign cnib = err ? 4'hF : {3'b000, cout};

    bcd_to_7seg u_cseg (
        .digit (cnib),
        .seg   (cseg)
    );

    assign hex[7*DIGITS +: 7] = cseg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4 and DIGITS=1).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] a4 = '0;
    logic [15:0] b4 = '0;
    logic        cin4 = 1'b0;
    logic        busy4, done4, cout4, err4;
    logic [15:0] sum4;
    logic [34:0] hex4;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1, done1, cout1, err1;
    logic [3:0]  sum1;
    logic [13:0] hex1;

    int tests = 0;
    int failed = 0;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .err   (err4),
        .hex   (hex4)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .err   (err1),
        .hex   (hex1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle and wait (bounded) for done.
    task automatic run4(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, output int lat);
        a4 = av;
        b4 = bv;
        cin4 = ci;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        @(negedge clk);
        @(negedge clk);

        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_err", err4, 0);
        chk("rst_hex", hex4, {5{S0}});
        rst_n = 1'b1;
        @(negedge clk);

        // 1234 + 8766 = 10000
        run4(16'h1234, 16'h8766, 1'b0, lat);
        chk("t1_lat", lat, 5);
        chk("t1_sum", sum4, 16'h0000);
        chk("t1_cout", cout4, 1);
        chk("t1_err", err4, 0);
        chk("t1_busy", busy4, 1);
        chk("t1_hex", hex4, {S1, {4{S0}}});
        @(negedge clk);
        chk("t1_busy_fall", busy4, 0);
        chk("t1_done_fall", done4, 0);

        // 9999 + 0000 + 1 = 10000
        run4(16'h9999, 16'h0000, 1'b1, lat);
        chk("t2a_lat", lat, 5);
        chk("t2a_sum", sum4, 16'h0000);
        chk("t2a_cout", cout4, 1);
        @(negedge clk);

        // 9999 + 9999 + 1 = 19999
        run4(16'h9999, 16'h9999, 1'b1, lat);
        chk("t2b_sum", sum4, 16'h9999);
        chk("t2b_cout", cout4, 1);
        chk("t2b_hex", hex4, {S1, {4{S9}}});
        @(negedge clk);

        // Non-BCD operand digit
        run4(16'h12A4, 16'h0001, 1'b0, lat);
        chk("t3_lat", lat, 1);
        chk("t3_err", err4, 1);
        chk("t3_sum", sum4, 0);
        chk("t3_cout", cout4, 0);
        chk("t3_hex", hex4, {5{SB}});
        @(negedge clk);
        chk("t3_err_hold", err4, 1);
        run4(16'h0001, 16'h0002, 1'b0, lat);
        chk("t3_clr_err", err4, 0);
        chk("t3_clr_sum", sum4, 16'h0003);
        chk("t3_clr_hex", hex4, {S0, S0, S0, S0, S3});
        @(negedge clk);

        // Start held high: accepted every 6 cycles, busy start ignored.
        a4 = 16'h1111;
        b4 = 16'h2222;
        cin4 = 1'b0;
        start4 = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) a4 = 16'h5555;
            if (done4) ndone++;
            if (i == 2) chk("t4_busy_start", busy4, 1);
            if (i == 5) begin
                chk("t4_done1", done4, 1);
                chk("t4_sum1", sum4, 16'h3333);
            end
            if (i == 6) chk("t4_nodone6", done4, 0);
            if (i == 7) chk("t4_sum_clr", sum4, 16'h0000);
            if (i == 11) begin
                chk("t4_done2", done4, 1);
                chk("t4_sum2", sum4, 16'h7777);
            end
            if (i == 12) start4 = 1'b0;
        end
        chk("t4_ndone", ndone, 2);
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle", busy4, 0);

        // Reset during ADD at idx 2
        a4 = 16'h1234;
        b4 = 16'h1111;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_pre", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy4, 0);
        chk("t5_sum", sum4, 0);
        chk("t5_hex", hex4, {5{S0}});
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("t5_nodone", ndone, 0);
        run4(16'h1234, 16'h1111, 1'b0, lat);
        chk("t5_lat", lat, 5);
        chk("t5_sum2", sum4, 16'h2345);
        @(negedge clk);

        // DIGITS=1 instance
        a1 = 4'h5;
        b1 = 4'h4;
        cin1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_lat", lat, 2);
        chk("t6_sum", sum1, 4'h9);
        chk("t6_cout", cout1, 0);
        chk("t6_hex", hex1, {S0, S9});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
